jk_bank_driver: RTL and testbench

Drives a bank of WIDTH external JK flip-flops to a requested target word, then checks the result. It accepts targets over a valid/ready handshake and generates per-bit J/K excitation from the flop outputs fed back to it. It verifies the outcome one cycle later and retries up to MAX_RETRY times before flagging an error. It is the write-side companion of our JK flip-flop cells and sits between control logic and any JK register bank.

---
 rtl/jk_bank_driver.sv | 125 ++++++++++++
 tb/tb_jk_bank_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives an external JK flop bank to a target word, verifies it, retries on mismatch.
// Build option: define JK_BANK_TOGGLE_EN to excite changing bits with toggle (j=k=1) instead of set/reset.
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] tgt_nxt;
  logic [WIDTH-1:0] drive_tgt;
  logic [WIDTH-1:0] need;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic [2:0]       retry_cnt;
  logic [2:0]       retry_nxt;
  logic [7:0]       err_cnt_nxt;
  logic             load_drive;

  // j/k are registered so the bank sees stable excitation for the whole DRIVE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tgt_q     <= '0;
      retry_cnt <= '0;
      j         <= '0;
      k         <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      tgt_q     <= tgt_nxt;
      retry_cnt <= retry_nxt;
      j         <= j_nxt;
      k         <= k_nxt;
      err_cnt   <= err_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tgt_nxt     = tgt_q;
    retry_nxt   = retry_cnt;
    err_cnt_nxt = err_cnt;
    drive_tgt   = tgt_q;
    load_drive  = 1'b0;
    tgt_ready   = 1'b0;
    done        = 1'b0;
    err         = 1'b0;

    case (state)
      IDLE: begin
        tgt_ready = ~rst;
        if (tgt_valid) begin
          tgt_nxt    = tgt_data;
          drive_tgt  = tgt_data;
          retry_nxt  = '0;
          load_drive = 1'b1;
          state_nxt  = DRIVE;
        end
      end

      DRIVE: begin
        state_nxt = CHECK;
      end

      // q_fb here already reflects the edge that left DRIVE
      CHECK: begin
        if (q_fb == tgt_q) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (int'(retry_cnt) < MAX_RETRY) begin
          retry_nxt  = retry_cnt + 3'd1;
          load_drive = 1'b1;
          state_nxt  = DRIVE;
        end else begin
          done      = 1'b1;
          err       = 1'b1;
          state_nxt = IDLE;
          if (err_cnt != 8'hFF) begin
            err_cnt_nxt = err_cnt + 8'd1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    need  = drive_tgt ^ q_fb;
    j_nxt = '0;
    k_nxt = '0;
    if (load_drive) begin
`ifdef JK_BANK_TOGGLE_EN
      j_nxt = need;
      k_nxt = need;
`else
      j_nxt = need & drive_tgt;
      k_nxt = need & ~drive_tgt;
`endif
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: ideal JK bank model (with stuck-at-0 injection) around jk_bank_driver,
// directed scenarios plus randomized targets checked against a transaction-level model.
module tb_jk_bank_driver;

  localparam int WIDTH     = 4;
  localparam int MAX_RETRY = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tgt_valid = 1'b0;
  logic [WIDTH-1:0] tgt_data = '0;
  logic             tgt_ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             done;
  logic             err;
  logic [7:0]       err_cnt;

  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] stuck0 = '0;
  logic             load_en = 1'b0;
  logic [WIDTH-1:0] load_val = '0;

  int total = 0;
  int bad = 0;
  int exp_err_cnt = 0;

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(tgt_ready), .q_fb(q_fb), .j(j), .k(k),
    .done(done), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Ideal JK flops on the shared clock; stuck0 bits can never become 1
  always @(posedge clk) begin
    if (load_en) bank_q <= load_val;
    else         bank_q <= ((j & ~bank_q) | (~k & bank_q)) & ~stuck0;
  end
  assign q_fb = bank_q;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setBank(input logic [WIDTH-1:0] v);
    load_val = v & ~stuck0;
    load_en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One full transaction; called and returns at a negedge
  task automatic applyStimulus(input logic [WIDTH-1:0] target);
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] ej;
    logic [WIDTH-1:0] ek;
    int tries;
    int waited;
    bit pass;
    waited = 0;
    while (tgt_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (tgt_ready !== 1'b1) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      return;
    end
    mq = bank_q;
    tgt_valid = 1'b1;
    tgt_data  = target;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
    tgt_data  = WIDTH'($urandom);
    tries = 0;
    forever begin
`ifdef JK_BANK_TOGGLE_EN
      ej = target ^ mq;
      ek = target ^ mq;
`else
      ej = target & ~mq;
      ek = ~target & mq;
`endif
      checkOutput("drive_j", 32'(j), 32'(ej));
      checkOutput("drive_k", 32'(k), 32'(ek));
      checkOutput("drive_done", 32'(done), 32'd0);
      checkOutput("drive_ready", 32'(tgt_ready), 32'd0);
      mq = target & ~stuck0;
      @(negedge clk);
      pass = (mq == target);
      checkOutput("check_jk", 32'({j, k}), 32'd0);
      checkOutput("check_ready", 32'(tgt_ready), 32'd0);
      if (pass || tries == MAX_RETRY) begin
        checkOutput("done", 32'(done), 32'd1);
        checkOutput("err", 32'(err), pass ? 32'd0 : 32'd1);
        if (!pass && exp_err_cnt < 255) exp_err_cnt++;
        break;
      end
      checkOutput("retry_done", 32'(done), 32'd0);
      tries++;
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("done_clear", 32'({done, err}), 32'd0);
    checkOutput("ready_back", 32'(tgt_ready), 32'd1);
    checkOutput("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    checkOutput("bank_q", 32'(bank_q), 32'(mq));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    setBank('0);
    @(negedge clk);
    checkOutput("rst_ready", 32'(tgt_ready), 32'd0);
    checkOutput("rst_jk", 32'({j, k}), 32'd0);
    checkOutput("rst_done", 32'({done, err}), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(tgt_ready), 32'd1);
    @(negedge clk);

    // Directed scenarios
    setBank(4'b0000);
    applyStimulus(4'b1010);
    setBank(4'b1111);
    applyStimulus(4'b0110);
    setBank(4'b0101);
    applyStimulus(4'b0101);
    stuck0 = 4'b0001;
    setBank(4'b0000);
    applyStimulus(4'b0001);
    stuck0 = '0;

    // Back-to-back with tgt_valid held
    setBank(4'h0);
    tgt_valid = 1'b1;
    tgt_data  = 4'h3;
    @(posedge clk);
    @(negedge clk);
    tgt_data = 4'hC;
    checkOutput("b2b_ready_c1", 32'(tgt_ready), 32'd0);
    checkOutput("b2b_j1", 32'(j), 32'h3);
    @(negedge clk);
    checkOutput("b2b_ready_c2", 32'(tgt_ready), 32'd0);
    checkOutput("b2b_done1", 32'({done, err}), 32'b10);
    @(negedge clk);
    checkOutput("b2b_ready_c3", 32'(tgt_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_ready_c4", 32'(tgt_ready), 32'd0);
    checkOutput("b2b_j2", 32'(j), 32'hC);
    checkOutput("b2b_k2", 32'(k), 32'h3);
    @(negedge clk);
    checkOutput("b2b_done2", 32'({done, err}), 32'b10);
    tgt_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_bank", 32'(bank_q), 32'hC);

    // Reset during DRIVE
    setBank(4'h0);
    tgt_valid = 1'b1;
    tgt_data  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
    checkOutput("mid_j", 32'(j), 32'hF);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_jk", 32'({j, k}), 32'd0);
    checkOutput("mid_rst_ready", 32'(tgt_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_bank", 32'(bank_q), 32'h0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    exp_err_cnt = 0;
    #1;
    checkOutput("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("mid_rst_ready_back", 32'(tgt_ready), 32'd1);
    @(negedge clk);

    // Randomized targets, bank states and stuck bits
    for (int n = 0; n < 60; n++) begin
      stuck0 = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
      setBank(WIDTH'($urandom));
      applyStimulus(WIDTH'($urandom));
    end

    // Drive err_cnt into saturation; err must keep pulsing
    stuck0 = 4'b0001;
    setBank(4'h0);
    for (int n = 0; n < 260; n++) begin
      applyStimulus(4'b0001);
    end
    checkOutput("sat_err_cnt", 32'(err_cnt), 32'd255);
    stuck0 = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
